// File: rtl/awg_sequencer.sv
// awg_sequencer: plays a small program of DC/ramp/triangle/square segments
// at ref_clk/DIV and produces the registered 8-bit offset-binary DAC sample.
module awg_sequencer #(
  parameter int NUM_SEG = 8,
  parameter int DIV     = 12,
  parameter int PHASE_W = 16,
  localparam int SEG_W  = $clog2(NUM_SEG)
) (
  input  logic               ref_clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [SEG_W-1:0]   cfg_addr,
  input  logic [1:0]         cfg_shape,
  input  logic [7:0]         cfg_amp,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic [15:0]        cfg_len,
  input  logic               cfg_last,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  output logic [7:0]         sample,
  output logic               sample_tick,
  output logic               busy,
  output logic [SEG_W-1:0]   seg_idx,
  output logic               done
);

  localparam int DIV_W = $clog2(DIV);
  localparam logic [SEG_W-1:0] LAST_IDX = SEG_W'(NUM_SEG - 1);
  localparam logic [7:0] MID = 8'd128;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e             state_q;
  logic [1:0]         segShape_q [NUM_SEG];
  logic [7:0]         segAmp_q   [NUM_SEG];
  logic [PHASE_W-1:0] segInc_q   [NUM_SEG];
  logic [15:0]        segLen_q   [NUM_SEG];
  logic               segLast_q  [NUM_SEG];

  logic [1:0]         wShape_q;
  logic [7:0]         wAmp_q;
  logic [PHASE_W-1:0] wInc_q;
  logic               wLast_q;
  logic [PHASE_W-1:0] phase_q;
  logic [DIV_W-1:0]   divCnt_q;
  logic [15:0]        remaining_q;
  logic [7:0]         sample_q;
  logic               sampleTick_q;
  logic               busy_q;
  logic [SEG_W-1:0]   segIdx_q;
  logic               done_q;

  logic [7:0]          u;
  logic [7:0]          w;
  logic signed [8:0]   diff;
  logic signed [16:0]  prod;
  logic [7:0]          sample_d;
  logic [PHASE_W-1:0]  phase_d;
  logic                segFinal;

  // Program store; writes land in any state and only matter at the next LOAD.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        segShape_q[i] <= '0;
        segAmp_q[i]   <= '0;
        segInc_q[i]   <= '0;
        segLen_q[i]   <= '0;
        segLast_q[i]  <= 1'b0;
      end
    end else if (cfg_we) begin
      segShape_q[cfg_addr] <= cfg_shape;
      segAmp_q[cfg_addr]   <= cfg_amp;
      segInc_q[cfg_addr]   <= cfg_inc;
      segLen_q[cfg_addr]   <= cfg_len;
      segLast_q[cfg_addr]  <= cfg_last;
    end
  end

  // Waveform lookup: amplitude scales the signed excursion around mid-scale.
  always_comb begin
    u = phase_q[PHASE_W-1 -: 8];
    case (wShape_q)
      2'd1:    w = u;
      2'd2:    w = u[7] ? ~{u[6:0], 1'b0} : {u[6:0], 1'b0};
      default: w = u[7] ? 8'd0 : 8'd255;
    endcase
    diff     = $signed({1'b0, w}) - 9'sd128;
    prod     = 17'(diff) * $signed({9'd0, wAmp_q});
    sample_d = (wShape_q == 2'd0) ? wAmp_q : 8'(prod >>> 8) + MID;
    phase_d  = phase_q + wInc_q;
    segFinal = ((state_q == LOAD) ? segLast_q[segIdx_q] : wLast_q) ||
               (segIdx_q == LAST_IDX);
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wShape_q     <= '0;
      wAmp_q       <= '0;
      wInc_q       <= '0;
      wLast_q      <= 1'b0;
      phase_q      <= '0;
      divCnt_q     <= '0;
      remaining_q  <= '0;
      sample_q     <= MID;
      sampleTick_q <= 1'b0;
      busy_q       <= 1'b0;
      segIdx_q     <= '0;
      done_q       <= 1'b0;
    end else begin
      sampleTick_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          sample_q <= MID;
          if (start && !stop) begin
            segIdx_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          if (stop) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            sample_q <= MID;
          end else begin
            wShape_q    <= segShape_q[segIdx_q];
            wAmp_q      <= segAmp_q[segIdx_q];
            wInc_q      <= segInc_q[segIdx_q];
            wLast_q     <= segLast_q[segIdx_q];
            phase_q     <= '0;
            divCnt_q    <= '0;
            remaining_q <= segLen_q[segIdx_q];
            // Zero-length segments end right here without producing a sample.
            if (segLen_q[segIdx_q] != 16'd0) begin
              state_q <= RUN;
            end else if (!segFinal) begin
              segIdx_q <= segIdx_q + SEG_W'(1);
            end else if (loop) begin
              segIdx_q <= '0;
            end else begin
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              sample_q <= MID;
              state_q  <= IDLE;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            sample_q <= MID;
          end else if (remaining_q == 16'd0) begin
            // Final tick already shown for one cycle; now finish.
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            sample_q <= MID;
            state_q  <= IDLE;
          end else if (divCnt_q == DIV_W'(DIV - 1)) begin
            divCnt_q     <= '0;
            sample_q     <= sample_d;
            sampleTick_q <= 1'b1;
            phase_q      <= phase_d;
            remaining_q  <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              if (!segFinal) begin
                segIdx_q <= segIdx_q + SEG_W'(1);
                state_q  <= LOAD;
              end else if (loop) begin
                segIdx_q <= '0;
                state_q  <= LOAD;
              end
            end
          end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample      = sample_q;
  assign sample_tick = sampleTick_q;
  assign busy        = busy_q;
  assign seg_idx     = segIdx_q;
  assign done        = done_q;

endmodule

// File: tb/tb_awg_sequencer.sv
// tb_awg_sequencer: drives segment programs into awg_sequencer and compares
// tick timing and sample values with an arithmetic model of the sequencer.
module tb_awg_sequencer;
  localparam int NUM_SEG = 8;
  localparam int DIV     = 12;
  localparam int PHASE_W = 16;
  localparam int SEG_W   = 3;

  logic               ref_clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_we = 1'b0;
  logic [SEG_W-1:0]   cfg_addr = '0;
  logic [1:0]         cfg_shape = '0;
  logic [7:0]         cfg_amp = '0;
  logic [PHASE_W-1:0] cfg_inc = '0;
  logic [15:0]        cfg_len = '0;
  logic               cfg_last = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               loop = 1'b0;
  logic [7:0]         sample;
  logic               sample_tick;
  logic               busy;
  logic [SEG_W-1:0]   seg_idx;
  logic               done;

  awg_sequencer #(.NUM_SEG(NUM_SEG), .DIV(DIV), .PHASE_W(PHASE_W)) dut (
    .ref_clk(ref_clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_shape(cfg_shape), .cfg_amp(cfg_amp), .cfg_inc(cfg_inc), .cfg_len(cfg_len),
    .cfg_last(cfg_last), .start(start), .stop(stop), .loop(loop), .sample(sample),
    .sample_tick(sample_tick), .busy(busy), .seg_idx(seg_idx), .done(done)
  );

  always #5 ref_clk = ~ref_clk;

  int cycle = 0;
  always @(posedge ref_clk) cycle <= cycle + 1;

  int errors = 0;
  int checks = 0;

  int mShape [NUM_SEG];
  int mAmp   [NUM_SEG];
  int mInc   [NUM_SEG];
  int mLen   [NUM_SEG];
  int mLast  [NUM_SEG];

  int expT[$];
  int expV[$];
  int expDone;
  int gotT[$];
  int gotV[$];
  int gotS[$];
  int segTrace[$];
  int doneAt, idleAt, idleSample, idleTick, doneCount;

  // Sample value straight from the shape definitions, with floor division.
  function automatic int modelSample(int shape, int amp, int phase);
    int u, w, p, r;
    u = phase / 256;
    case (shape)
      1:       w = u;
      2:       w = (u < 128) ? 2 * u : 255 - 2 * (u - 128);
      default: w = (u < 128) ? 255 : 0;
    endcase
    p = (w - 128) * amp;
    r = (p >= 0) ? 128 + p / 256 : 128 - ((-p + 255) / 256);
    if (shape == 0) r = amp;
    return r;
  endfunction

  // Timeline model without looping: each LOAD costs one cycle, each sample DIV.
  task automatic buildExpected();
    int t, s, ph;
    expT.delete();
    expV.delete();
    expDone = -1;
    t = 0;
    s = 0;
    for (int g = 0; g < NUM_SEG; g++) begin
      t += 1;
      ph = 0;
      for (int k = 0; k < mLen[s]; k++) begin
        t += DIV;
        expT.push_back(t);
        expV.push_back(modelSample(mShape[s], mAmp[s], ph));
        ph = (ph + mInc[s]) % 65536;
      end
      if (mLast[s] != 0 || s == NUM_SEG - 1) begin
        expDone = (mLen[s] > 0) ? t + 1 : t;
        break;
      end
      s++;
    end
  endtask

  task automatic writeSeg(input int a, input int sh, input int am, input int inc,
                          input int ln, input int la);
    @(negedge ref_clk);
    cfg_we = 1'b1;
    cfg_addr = SEG_W'(a);
    cfg_shape = 2'(sh);
    cfg_amp = 8'(am);
    cfg_inc = 16'(inc);
    cfg_len = 16'(ln);
    cfg_last = (la != 0);
    mShape[a] = sh;
    mAmp[a] = am;
    mInc[a] = inc;
    mLen[a] = ln;
    mLast[a] = la;
    @(negedge ref_clk);
    cfg_we = 1'b0;
  endtask

  task automatic clearProgram();
    for (int i = 0; i < NUM_SEG; i++) writeSeg(i, 0, 0, 0, 0, 0);
  endtask

  task automatic clearModel();
    for (int i = 0; i < NUM_SEG; i++) begin
      mShape[i] = 0; mAmp[i] = 0; mInc[i] = 0; mLen[i] = 0; mLast[i] = 0;
    end
  endtask

  // Starts playback and records ticks relative to the start edge until busy drops.
  task automatic runProgram(input int maxCycles, input int stopAt, input int pokeAt);
    int rel, lastSeg, e0;
    gotT.delete(); gotV.delete(); gotS.delete(); segTrace.delete();
    doneAt = -1; idleAt = -1; idleSample = -1; idleTick = -1; doneCount = 0;
    @(negedge ref_clk);
    start = 1'b1;
    stop = 1'b0;
    @(negedge ref_clk);
    start = 1'b0;
    e0 = cycle;
    lastSeg = int'(seg_idx);
    segTrace.push_back(lastSeg);
    for (int n = 0; n < maxCycles; n++) begin
      rel = cycle - e0;
      if (sample_tick) begin
        gotT.push_back(rel);
        gotV.push_back(int'(sample));
        gotS.push_back(int'(seg_idx));
      end
      if (done) begin
        doneCount++;
        if (doneAt < 0) doneAt = rel;
      end
      if (int'(seg_idx) != lastSeg) begin
        lastSeg = int'(seg_idx);
        segTrace.push_back(lastSeg);
      end
      if (!busy) begin
        idleAt = rel;
        idleSample = int'(sample);
        idleTick = int'(sample_tick);
        break;
      end
      stop = (rel == stopAt);
      start = (rel == pokeAt);
      @(negedge ref_clk);
    end
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearModel();
    repeat (3) @(negedge ref_clk);
    checks += 5;
    if (sample !== 8'd128) begin errors++; $display("[TB] FAIL reset_sample got=%0d exp=128", sample); end
    if (sample_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got=%0b exp=0", sample_tick); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    if (seg_idx !== 3'd0) begin errors++; $display("[TB] FAIL reset_seg got=%0d exp=0", seg_idx); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
    rst_n = 1'b1;
  endtask

  task automatic test_dc();
    clearProgram();
    writeSeg(0, 0, 200, 0, 3, 1);
    loop = 1'b0;
    buildExpected();
    runProgram(300, -1, -1);
    checks++;
    if (gotV.size() !== expV.size()) begin errors++; $display("[TB] FAIL dc_count got=%0d exp=%0d", gotV.size(), expV.size()); end
    for (int i = 0; i < expV.size() && i < gotV.size(); i++) begin
      checks += 2;
      if (gotV[i] !== expV[i]) begin errors++; $display("[TB] FAIL dc_value[%0d] got=%0d exp=%0d", i, gotV[i], expV[i]); end
      if (gotT[i] !== expT[i]) begin errors++; $display("[TB] FAIL dc_time[%0d] got=%0d exp=%0d", i, gotT[i], expT[i]); end
    end
    checks += 4;
    if (doneAt !== expDone) begin errors++; $display("[TB] FAIL dc_done got=%0d exp=%0d", doneAt, expDone); end
    if (idleAt !== expDone) begin errors++; $display("[TB] FAIL dc_busy_fall got=%0d exp=%0d", idleAt, expDone); end
    if (idleSample !== 128) begin errors++; $display("[TB] FAIL dc_idle_sample got=%0d exp=128", idleSample); end
    if (doneCount !== 1) begin errors++; $display("[TB] FAIL dc_done_pulses got=%0d exp=1", doneCount); end
  endtask

  task automatic test_ramp();
    clearProgram();
    writeSeg(0, 1, 255, 16'h1000, 16, 1);
    buildExpected();
    runProgram(400, -1, -1);
    checks++;
    if (gotV.size() !== expV.size()) begin errors++; $display("[TB] FAIL ramp_count got=%0d exp=%0d", gotV.size(), expV.size()); end
    for (int i = 0; i < expV.size() && i < gotV.size(); i++) begin
      checks += 2;
      if (gotV[i] !== expV[i]) begin errors++; $display("[TB] FAIL ramp_value[%0d] got=%0d exp=%0d", i, gotV[i], expV[i]); end
      if (gotT[i] !== expT[i]) begin errors++; $display("[TB] FAIL ramp_time[%0d] got=%0d exp=%0d", i, gotT[i], expT[i]); end
    end
    if (gotV.size() == 16) begin
      checks += 2;
      if (gotV[0] !== 0) begin errors++; $display("[TB] FAIL ramp_first got=%0d exp=0", gotV[0]); end
      if (gotV[15] !== 239) begin errors++; $display("[TB] FAIL ramp_last got=%0d exp=239", gotV[15]); end
    end
    checks++;
    if (doneAt !== expDone) begin errors++; $display("[TB] FAIL ramp_done got=%0d exp=%0d", doneAt, expDone); end
  endtask

  task automatic test_square_segments();
    int expSq[5] = '{191, 64, 191, 64, 10};
    clearProgram();
    writeSeg(0, 3, 128, 16'h8000, 4, 0);
    writeSeg(1, 0, 10, 0, 1, 1);
    buildExpected();
    runProgram(300, -1, -1);
    checks++;
    if (gotV.size() !== 5) begin errors++; $display("[TB] FAIL sq_count got=%0d exp=5", gotV.size()); end
    for (int i = 0; i < 5 && i < gotV.size(); i++) begin
      checks += 2;
      if (gotV[i] !== expSq[i]) begin errors++; $display("[TB] FAIL sq_value[%0d] got=%0d exp=%0d", i, gotV[i], expSq[i]); end
      if (gotT[i] !== expT[i]) begin errors++; $display("[TB] FAIL sq_time[%0d] got=%0d exp=%0d", i, gotT[i], expT[i]); end
    end
    if (gotV.size() == 5) begin
      checks += 3;
      if (gotT[4] - gotT[3] !== DIV + 1) begin errors++; $display("[TB] FAIL sq_boundary_gap got=%0d exp=%0d", gotT[4] - gotT[3], DIV + 1); end
      if (gotS[0] !== 0) begin errors++; $display("[TB] FAIL sq_seg_first got=%0d exp=0", gotS[0]); end
      if (gotS[4] !== 1) begin errors++; $display("[TB] FAIL sq_seg_last got=%0d exp=1", gotS[4]); end
    end
    checks++;
    if (doneAt !== expDone) begin errors++; $display("[TB] FAIL sq_done got=%0d exp=%0d", doneAt, expDone); end
  endtask

  task automatic test_skip_loop();
    int expTrace[4] = '{0, 1, 2, 0};
    int doneSeen;
    bit fell;
    clearProgram();
    writeSeg(0, 0, 1, 0, 2, 0);
    writeSeg(1, 0, 99, 0, 0, 0);
    writeSeg(2, 0, 3, 0, 1, 1);
    buildExpected();
    loop = 1'b1;
    runProgram(3 * DIV + 10, -1, -1);
    checks += 3;
    if (segTrace.size() !== 4) begin errors++; $display("[TB] FAIL loop_trace_len got=%0d exp=4", segTrace.size()); end
    if (gotV.size() !== 3) begin errors++; $display("[TB] FAIL loop_ticks got=%0d exp=3", gotV.size()); end
    if (doneCount !== 0) begin errors++; $display("[TB] FAIL loop_done got=%0d exp=0", doneCount); end
    for (int i = 0; i < 4 && i < segTrace.size(); i++) begin
      checks++;
      if (segTrace[i] !== expTrace[i]) begin errors++; $display("[TB] FAIL loop_trace[%0d] got=%0d exp=%0d", i, segTrace[i], expTrace[i]); end
    end
    for (int i = 0; i < 3 && i < gotV.size(); i++) begin
      checks += 2;
      if (gotV[i] !== expV[i]) begin errors++; $display("[TB] FAIL loop_value[%0d] got=%0d exp=%0d", i, gotV[i], expV[i]); end
      if (gotT[i] !== expT[i]) begin errors++; $display("[TB] FAIL loop_time[%0d] got=%0d exp=%0d", i, gotT[i], expT[i]); end
    end
    loop = 1'b0;
    doneSeen = 0;
    fell = 1'b0;
    for (int n = 0; n < 200 && !fell; n++) begin
      @(negedge ref_clk);
      if (done) doneSeen++;
      if (!busy) fell = 1'b1;
    end
    checks += 3;
    if (fell !== 1'b1) begin errors++; $display("[TB] FAIL unloop_busy_fall got=%0b exp=1", fell); end
    if (doneSeen !== 1) begin errors++; $display("[TB] FAIL unloop_done got=%0d exp=1", doneSeen); end
    if (sample !== 8'd128) begin errors++; $display("[TB] FAIL unloop_sample got=%0d exp=128", sample); end
  endtask

  task automatic test_stop_collisions();
    int lateDone;
    clearProgram();
    writeSeg(0, 0, 50, 0, 10, 1);
    runProgram(300, 2 * DIV, -1);
    checks += 5;
    if (gotV.size() !== 1) begin errors++; $display("[TB] FAIL stop_ticks got=%0d exp=1", gotV.size()); end
    if (idleAt !== 2 * DIV + 1) begin errors++; $display("[TB] FAIL stop_idle_time got=%0d exp=%0d", idleAt, 2 * DIV + 1); end
    if (idleSample !== 128) begin errors++; $display("[TB] FAIL stop_sample got=%0d exp=128", idleSample); end
    if (idleTick !== 0) begin errors++; $display("[TB] FAIL stop_tick got=%0d exp=0", idleTick); end
    if (doneCount !== 0) begin errors++; $display("[TB] FAIL stop_done got=%0d exp=0", doneCount); end
    lateDone = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge ref_clk);
      if (done) lateDone++;
    end
    checks++;
    if (lateDone !== 0) begin errors++; $display("[TB] FAIL stop_late_done got=%0d exp=0", lateDone); end
    @(negedge ref_clk);
    start = 1'b1;
    stop = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL start_with_stop_busy got=%0b exp=0", busy); end
    writeSeg(0, 0, 77, 0, 3, 1);
    buildExpected();
    runProgram(300, -1, 5);
    checks += 2;
    if (gotV.size() !== expV.size()) begin errors++; $display("[TB] FAIL busy_start_ticks got=%0d exp=%0d", gotV.size(), expV.size()); end
    if (doneAt !== expDone) begin errors++; $display("[TB] FAIL busy_start_done got=%0d exp=%0d", doneAt, expDone); end
  endtask

  task automatic test_reset_midrun();
    clearProgram();
    writeSeg(0, 1, 255, 16'h1000, 16, 1);
    @(negedge ref_clk);
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    repeat (30) @(negedge ref_clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (sample !== 8'd128) begin errors++; $display("[TB] FAIL midreset_sample got=%0d exp=128", sample); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got=%0b exp=0", busy); end
    if (sample_tick !== 1'b0) begin errors++; $display("[TB] FAIL midreset_tick got=%0b exp=0", sample_tick); end
    if (seg_idx !== 3'd0) begin errors++; $display("[TB] FAIL midreset_seg got=%0d exp=0", seg_idx); end
    clearModel();
    @(negedge ref_clk);
    rst_n = 1'b1;
    loop = 1'b0;
    buildExpected();
    runProgram(100, -1, -1);
    checks += 3;
    if (gotV.size() !== 0) begin errors++; $display("[TB] FAIL midreset_ticks got=%0d exp=0", gotV.size()); end
    if (doneAt !== expDone) begin errors++; $display("[TB] FAIL midreset_done got=%0d exp=%0d", doneAt, expDone); end
    if (doneCount !== 1) begin errors++; $display("[TB] FAIL midreset_done_pulses got=%0d exp=1", doneCount); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < NUM_SEG; s++) begin
        writeSeg(s, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 4)),
                 ($urandom_range(0, 3) == 0) ? 1 : 0);
      end
      loop = 1'b0;
      buildExpected();
      runProgram(2000, -1, -1);
      checks += 2;
      if (gotV.size() !== expV.size()) begin errors++; $display("[TB] FAIL rand%0d_count got=%0d exp=%0d", it, gotV.size(), expV.size()); end
      if (doneAt !== expDone) begin errors++; $display("[TB] FAIL rand%0d_done got=%0d exp=%0d", it, doneAt, expDone); end
      for (int i = 0; i < expV.size() && i < gotV.size(); i++) begin
        checks += 2;
        if (gotV[i] !== expV[i]) begin errors++; $display("[TB] FAIL rand%0d_value[%0d] got=%0d exp=%0d", it, i, gotV[i], expV[i]); end
        if (gotT[i] !== expT[i]) begin errors++; $display("[TB] FAIL rand%0d_time[%0d] got=%0d exp=%0d", it, i, gotT[i], expT[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_ramp();
    test_square_segments();
    test_skip_loop();
    test_stop_collisions();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
